// File: rtl/mips_pkg.sv
// Shared fetch-path definitions: NOP encoding, default reset PC, fetch FSM states.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package mips_pkg;

    localparam logic [31:0] NOP              = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Fetch FSM encoding
    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    // Instruction addresses are always word aligned.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_unit.sv
// Program counter register with +4 increment and branch-redirect mux.
// Latency: new PC visible one cycle after i_inc/i_redir; o_pc_plus4 is combinational.
// Backpressure: none; redirect wins over increment, PC holds when neither is asserted.
module pc_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_inc,
    input  logic        i_redir,
    input  logic [31:0] i_target,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    // Increment wraps naturally at 2^32.
    assign o_pc_plus4 = pc_q + 32'd4;
    assign o_pc       = pc_q;

    // Next PC: redirect target (aligned) beats sequential increment.
    always_comb begin
        pc_d = pc_q;
        if (i_redir) begin
            pc_d = align_word(i_target);
        end else if (i_inc) begin
            pc_d = o_pc_plus4;
        end
    end

    // PC register, reset to an aligned RESET_PC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= align_word(RESET_PC);
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: one outstanding IM request, FETCH/WAIT/HOLD FSM, registered ID outputs.
// Latency: word returned on edge N is on the outputs after edge N; 2 cycles/instr with zero-wait memory.
// Backpressure: Stall freezes the output register (a word arriving then parks in a hold buffer);
//               redirect overrides everything. Define IF_PERF_CNT_EN to add o_IF_perf_FetchCnt.
module if_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          IM_AW    = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             o_IM_req,
    output logic [IM_AW-1:0] o_IM_addr,
    input  logic             i_IM_ready,
    input  logic             i_IM_rvalid,
    input  logic [31:0]      i_IM_rdata,
    input  logic             i_IF_ctrl_Stall,
    input  logic             i_IF_ctrl_PCSrc,
    input  logic [31:0]      i_IF_data_BranchTarget,
    output logic [31:0]      o_ID_data_instruction,
    output logic             o_ID_ctrl_Valid,
    output logic [31:0]      o_EX_data_PCNext
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]      o_IF_perf_FetchCnt
`endif
);

    logic [1:0]  state_q, state_d;
    logic        drop_q, drop_d;
    logic [31:0] hold_q, hold_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic [31:0] pcnext_q, pcnext_d;

    logic        deliver;
    logic [31:0] deliver_word;
    logic [31:0] pc;
    logic [31:0] pc_plus4;

    pc_unit #(
        .RESET_PC (RESET_PC)
    ) u_pc_unit (
        .clk        (clk),
        .rst        (rst),
        .i_inc      (deliver),
        .i_redir    (i_IF_ctrl_PCSrc),
        .i_target   (i_IF_data_BranchTarget),
        .o_pc       (pc),
        .o_pc_plus4 (pc_plus4)
    );

    // Request only in FETCH; address tracks PC, which moves only on delivery (not in FETCH) or redirect.
    assign o_IM_req = (state_q == ST_FETCH);

    generate
        if (IM_AW <= 32) begin : g_addr_trunc
            assign o_IM_addr = pc[IM_AW-1:0];
        end else begin : g_addr_ext
            assign o_IM_addr = {{(IM_AW-32){1'b0}}, pc};
        end
    endgenerate

    assign o_ID_data_instruction = instr_q;
    assign o_ID_ctrl_Valid       = valid_q;
    assign o_EX_data_PCNext      = pcnext_q;

    // FSM, drop flag, hold buffer and output register next-state.
    always_comb begin
        state_d      = state_q;
        drop_d       = drop_q;
        hold_d       = hold_q;
        instr_d      = instr_q;
        valid_d      = valid_q;
        pcnext_d     = pcnext_q;
        deliver      = 1'b0;
        deliver_word = NOP;

        if (i_IF_ctrl_PCSrc) begin
            // Redirect: whatever is in flight or buffered belongs to the wrong path.
            instr_d = NOP;
            valid_d = 1'b0;
            case (state_q)
                ST_FETCH: begin
                    if (i_IM_ready) begin
                        state_d = ST_WAIT;
                        drop_d  = 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (i_IM_rvalid) begin
                        state_d = ST_FETCH;
                        drop_d  = 1'b0;
                    end else begin
                        drop_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_FETCH;
                end
            endcase
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (i_IM_ready) begin
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (i_IM_rvalid) begin
                        if (drop_q) begin
                            drop_d  = 1'b0;
                            state_d = ST_FETCH;
                        end else if (!i_IF_ctrl_Stall) begin
                            deliver      = 1'b1;
                            deliver_word = i_IM_rdata;
                            state_d      = ST_FETCH;
                        end else begin
                            hold_d  = i_IM_rdata;
                            state_d = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!i_IF_ctrl_Stall) begin
                        deliver      = 1'b1;
                        deliver_word = hold_q;
                        state_d      = ST_FETCH;
                    end
                end
                default: begin
                    state_d = ST_FETCH;
                end
            endcase

            if (deliver) begin
                instr_d  = deliver_word;
                valid_d  = 1'b1;
                pcnext_d = pc_plus4;
            end else if (!i_IF_ctrl_Stall) begin
                instr_d = NOP;
                valid_d = 1'b0;
            end
        end
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_FETCH;
            drop_q   <= 1'b0;
            hold_q   <= NOP;
            instr_q  <= NOP;
            valid_q  <= 1'b0;
            pcnext_q <= 32'h0000_0000;
        end else begin
            state_q  <= state_d;
            drop_q   <= drop_d;
            hold_q   <= hold_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
            pcnext_q <= pcnext_d;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;

    assign o_IF_perf_FetchCnt = fetch_cnt_q;

    // Count instructions actually handed to decode.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        if (deliver) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
    end

    // Delivered-instruction counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_q <= 32'h0000_0000;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: cycle vector table, random memory/stall scoreboard,
// and hand sequences for async reset, PC wrap and (optionally) the fetch counter.
module tb_if_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        im_req;
    logic [31:0] im_addr;
    logic        ready, rvalid, stall, pcsrc;
    logic [31:0] rdata, target;
    logic [31:0] instr, pcnext;
    logic        valid;

    logic        w_req, w_ready, w_rvalid, w_valid;
    logic [31:0] w_addr, w_rdata, w_instr, w_pcnext;

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf, w_perf;
`endif

    if_stage u_dut (
        .clk                    (clk),
        .rst                    (rst),
        .o_IM_req               (im_req),
        .o_IM_addr              (im_addr),
        .i_IM_ready             (ready),
        .i_IM_rvalid            (rvalid),
        .i_IM_rdata             (rdata),
        .i_IF_ctrl_Stall        (stall),
        .i_IF_ctrl_PCSrc        (pcsrc),
        .i_IF_data_BranchTarget (target),
        .o_ID_data_instruction  (instr),
        .o_ID_ctrl_Valid        (valid),
        .o_EX_data_PCNext       (pcnext)
`ifdef IF_PERF_CNT_EN
        ,
        .o_IF_perf_FetchCnt     (perf)
`endif
    );

    if_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk                    (clk),
        .rst                    (rst),
        .o_IM_req               (w_req),
        .o_IM_addr              (w_addr),
        .i_IM_ready             (w_ready),
        .i_IM_rvalid            (w_rvalid),
        .i_IM_rdata             (w_rdata),
        .i_IF_ctrl_Stall        (1'b0),
        .i_IF_ctrl_PCSrc        (1'b0),
        .i_IF_data_BranchTarget (32'h0000_0000),
        .o_ID_data_instruction  (w_instr),
        .o_ID_ctrl_Valid        (w_valid),
        .o_EX_data_PCNext       (w_pcnext)
`ifdef IF_PERF_CNT_EN
        ,
        .o_IF_perf_FetchCnt     (w_perf)
`endif
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    typedef struct {
        logic        ready;
        logic        rvalid;
        logic [31:0] rdata;
        logic        stall;
        logic        pcsrc;
        logic [31:0] target;
        logic        ereq;
        logic [31:0] eaddr;
        logic [31:0] einstr;
        logic        evalid;
        logic [31:0] epcnext;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pcnext;
    } exp_t;

    localparam int NVEC = 21;
    vec_t vt [NVEC];
    exp_t sb_q [$];

    function automatic vec_t mk(input logic r, input logic v, input logic [31:0] d,
                                input logic s, input logic p, input logic [31:0] t,
                                input logic eq, input logic [31:0] ea,
                                input logic [31:0] ei, input logic ev, input logic [31:0] en);
        vec_t x;
        x.ready = r;  x.rvalid = v; x.rdata = d;  x.stall = s; x.pcsrc = p; x.target = t;
        x.ereq  = eq; x.eaddr  = ea; x.einstr = ei; x.evalid = ev; x.epcnext = en;
        return x;
    endfunction

    task automatic do_reset();
        ready = 0; rvalid = 0; rdata = 0; stall = 0; pcsrc = 0; target = 0;
        w_ready = 0; w_rvalid = 0; w_rdata = 0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_addr;
        logic [31:0] pend_addr;
        bit          pending;
        int          pend_cnt;
        int          delivered;
        exp_t        e;

        //        rdy rv rdata         st pc target        req addr          instr         v  pcnext
        vt[0]  = mk(1, 0, 32'h0,        0, 0, 32'h0,   1, 32'h0,   32'h0,         0, 32'h0);
        vt[1]  = mk(0, 1, 32'h2002_0005,0, 0, 32'h0,   0, 32'h0,   32'h2002_0005, 1, 32'h4);
        vt[2]  = mk(1, 0, 32'h0,        1, 0, 32'h0,   1, 32'h4,   32'h2002_0005, 1, 32'h4);
        vt[3]  = mk(0, 1, 32'h8C43_0000,1, 0, 32'h0,   0, 32'h0,   32'h2002_0005, 1, 32'h4);
        vt[4]  = mk(0, 0, 32'h0,        1, 0, 32'h0,   0, 32'h0,   32'h2002_0005, 1, 32'h4);
        vt[5]  = mk(0, 0, 32'h0,        0, 0, 32'h0,   0, 32'h0,   32'h8C43_0000, 1, 32'h8);
        vt[6]  = mk(1, 0, 32'h0,        0, 0, 32'h0,   1, 32'h8,   32'h0,         0, 32'h8);
        vt[7]  = mk(0, 0, 32'h0,        0, 1, 32'h102, 0, 32'h0,   32'h0,         0, 32'h8);
        vt[8]  = mk(0, 1, 32'hDEAD_BEEF,0, 0, 32'h0,   0, 32'h0,   32'h0,         0, 32'h8);
        vt[9]  = mk(0, 0, 32'h0,        0, 0, 32'h0,   1, 32'h100, 32'h0,         0, 32'h8);
        vt[10] = mk(0, 0, 32'h0,        0, 1, 32'h203, 1, 32'h100, 32'h0,         0, 32'h8);
        vt[11] = mk(1, 0, 32'h0,        0, 0, 32'h0,   1, 32'h200, 32'h0,         0, 32'h8);
        vt[12] = mk(0, 1, 32'h1111_2222,0, 0, 32'h0,   0, 32'h0,   32'h1111_2222, 1, 32'h204);
        vt[13] = mk(1, 0, 32'h0,        1, 1, 32'h300, 1, 32'h204, 32'h0,         0, 32'h204);
        vt[14] = mk(0, 1, 32'h3333_4444,0, 0, 32'h0,   0, 32'h0,   32'h0,         0, 32'h204);
        vt[15] = mk(1, 0, 32'h0,        0, 0, 32'h0,   1, 32'h300, 32'h0,         0, 32'h204);
        vt[16] = mk(0, 1, 32'h5555_6666,1, 0, 32'h0,   0, 32'h0,   32'h0,         0, 32'h204);
        vt[17] = mk(0, 0, 32'h0,        1, 1, 32'h400, 0, 32'h0,   32'h0,         0, 32'h204);
        vt[18] = mk(1, 0, 32'h0,        0, 0, 32'h0,   1, 32'h400, 32'h0,         0, 32'h204);
        vt[19] = mk(0, 1, 32'h6666_7777,0, 1, 32'h500, 0, 32'h0,   32'h0,         0, 32'h204);
        vt[20] = mk(0, 0, 32'h0,        0, 0, 32'h0,   1, 32'h500, 32'h0,         0, 32'h204);

        // Reset state
        ready = 0; rvalid = 0; rdata = 0; stall = 0; pcsrc = 0; target = 0;
        w_ready = 0; w_rvalid = 0; w_rdata = 0;
        rst = 1'b1;
        #1;
        check("rst instr",  instr, 32'h0);
        check("rst valid",  {31'b0, valid}, 32'h0);
        check("rst pcnext", pcnext, 32'h0);
        check("rst addr",   im_addr, 32'h0);
        check("rst wrap addr", w_addr, 32'hFFFF_FFFC);
        @(posedge clk);
        #1 rst = 1'b0;

        // Directed cycle table
        for (int i = 0; i < NVEC; i++) begin
            ready = vt[i].ready; rvalid = vt[i].rvalid; rdata = vt[i].rdata;
            stall = vt[i].stall; pcsrc = vt[i].pcsrc;   target = vt[i].target;
            #2;
            check($sformatf("v%0d req", i), {31'b0, im_req}, {31'b0, vt[i].ereq});
            if (vt[i].ereq) check($sformatf("v%0d addr", i), im_addr, vt[i].eaddr);
            @(posedge clk);
            #1;
            check($sformatf("v%0d instr", i),  instr, vt[i].einstr);
            check($sformatf("v%0d valid", i),  {31'b0, valid}, {31'b0, vt[i].evalid});
            check($sformatf("v%0d pcnext", i), pcnext, vt[i].epcnext);
        end

        // Random memory latency / stall stream against a scoreboard
        exp_addr  = 32'h500;
        pending   = 0;
        pend_cnt  = 0;
        pend_addr = 0;
        delivered = 0;
        for (int c = 0; c < 300; c++) begin
            pcsrc = 0; target = 0;
            if (pending && pend_cnt == 0) begin
                rvalid = 1; rdata = mem_word(pend_addr);
                e.instr = mem_word(pend_addr); e.pcnext = pend_addr + 32'd4;
                sb_q.push_back(e);
                pending = 0;
            end else begin
                rvalid = 0; rdata = 0;
                if (pending) pend_cnt--;
            end
            stall = (c < 290) ? ($urandom_range(0, 2) == 0) : 1'b0;
            ready = (c < 290) ? 1'($urandom_range(0, 1)) : 1'b0;
            #2;
            if (im_req && ready) begin
                check("sb addr", im_addr, exp_addr);
                pend_addr = exp_addr;
                pending   = 1;
                pend_cnt  = $urandom_range(0, 2);
                exp_addr  = exp_addr + 32'd4;
            end
            @(posedge clk);
            #1;
            if (!stall && valid) begin
                if (sb_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL sb unexpected: got %h, expected no delivery", instr);
                end else begin
                    e = sb_q.pop_front();
                    check("sb instr", instr, e.instr);
                    check("sb pcnext", pcnext, e.pcnext);
                    delivered++;
                end
            end
        end
        check("sb drained", 32'(sb_q.size()), 32'h0);
        check("sb delivered some", {31'b0, delivered > 0}, 32'h1);

        // Async reset asserted between edges while WAIT is outstanding
        do_reset();
        ready = 1;
        @(posedge clk); #1;
        ready = 0; rvalid = 1; rdata = 32'hABCD_0123;
        @(posedge clk); #1;
        rvalid = 0;
        check("pre-rst instr", instr, 32'hABCD_0123);
        ready = 1;
        @(posedge clk); #1;
        ready = 0;
        #3 rst = 1'b1;
        #1;
        check("async rst instr",  instr, 32'h0);
        check("async rst valid",  {31'b0, valid}, 32'h0);
        check("async rst pcnext", pcnext, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        #2;
        check("post-rst req",  {31'b0, im_req}, 32'h1);
        check("post-rst addr", im_addr, 32'h0);

        // PC wrap with RESET_PC = FFFF_FFFC
        do_reset();
        w_ready = 1;
        #2;
        check("wrap req0 addr", w_addr, 32'hFFFF_FFFC);
        @(posedge clk); #1;
        w_ready = 0; w_rvalid = 1; w_rdata = 32'h0BAD_F00D;
        @(posedge clk); #1;
        w_rvalid = 0;
        check("wrap instr",  w_instr, 32'h0BAD_F00D);
        check("wrap pcnext", w_pcnext, 32'h0);
        #2;
        check("wrap req1",      {31'b0, w_req}, 32'h1);
        check("wrap req1 addr", w_addr, 32'h0);

`ifdef IF_PERF_CNT_EN
        // Fetch counter: ten delivered words, one discarded by redirect
        do_reset();
        check("perf reset", perf, 32'h0);
        for (int k = 0; k < 10; k++) begin
            ready = 1;
            @(posedge clk); #1;
            ready = 0; rvalid = 1; rdata = 32'h100 + k;
            @(posedge clk); #1;
            rvalid = 0;
        end
        ready = 1;
        @(posedge clk); #1;
        ready = 0; pcsrc = 1; target = 32'h40;
        @(posedge clk); #1;
        pcsrc = 0; rvalid = 1; rdata = 32'hFFFF_0000;
        @(posedge clk); #1;
        rvalid = 0;
        check("perf count", perf, 32'd10);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
